imem_line_responder: RTL and testbench
======================================

# imem_line_responder

Responder end of the instruction-fetch port. It sits between the frontend's imem initiator (`imem_addr`/`imem_rmask` in, `imem_resp` out) and the burst-based backing memory. It holds one 32-byte line in a buffer and serves hits one cycle after the request. On a miss it runs a 4-beat burst refill, then returns the requested word, with squash support for requests made stale by a branch flush.

## Interface
- `BURST_LEN`, default 4: beats per refill; line size is `BURST_LEN*8` bytes.
- `DATA_W`, default 64: backing-memory beat width in bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `imem_rmask` in 4: any nonzero value is a request; held level by the initiator until `imem_resp`.
- `flush` in 1: frontend redirect; squashes any outstanding request.
- `imem_rdata` out 32: instruction word; valid only with `imem_resp`.
- `imem_resp` out 1: one-cycle response pulse.
- `bmem_addr` out 32: line-aligned refill address.
- `bmem_read` out 1: refill request; held until `bmem_ready`.
- `bmem_ready` in 1: backing memory accepts the request this cycle.
- `bmem_rvalid` in 1: beat valid.
- `bmem_rdata` in DATA_W: beat data, ascending order from the line base.

## Operation
- State is `line_valid`, `line_tag` (addr[31:5]) and `line_data` (256 b).
- Latched request: `req_addr` and `squash` flag.
- FSM states: IDLE, HIT_RESP, MISS_REQ, MISS_FILL, FILL_RESP.
- **Acceptance:** a request is accepted only in IDLE, with `imem_rmask != 0`, `imem_resp == 0` and `flush == 0`. `imem_addr` is latched into `req_addr`.
- **Hit** (`line_valid` and tag match): IDLE -> HIT_RESP. HIT_RESP asserts `imem_resp` with word `req_addr[4:2]`, then -> IDLE.
- **Miss:** IDLE -> MISS_REQ.
  - MISS_REQ drives `bmem_read=1` and `bmem_addr={req_addr[31:5],5'b0}`.
  - On `bmem_ready` -> MISS_FILL, beat counter = 0.
- **MISS_FILL:** each `bmem_rvalid` writes beat `cnt` into bits [cnt*64 +: 64] and increments the 2-bit counter.
  - On the beat with `cnt == BURST_LEN-1`: set `line_valid` and `line_tag`, then -> FILL_RESP.
  - `line_valid` is cleared when MISS_REQ is entered, so a partial line is never hit.
- **FILL_RESP:** asserts `imem_resp` with the requested word unless `squash`, then -> IDLE.
- **Flush:**
  - In HIT_RESP or FILL_RESP: `imem_resp` is forced to 0.
  - In MISS_REQ or MISS_FILL: sets `squash`. The burst is not cancellable; the refill completes and the line is retained.
  - `squash` clears on return to IDLE.
- `imem_rmask` dropping to 0 mid-miss has no effect; the refill completes.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE; `line_valid=0`.
  - `imem_resp=0`, `imem_rdata=0`, `bmem_read=0`, `bmem_addr=0`.
  - Counter and `squash` cleared.
  - Reset mid-burst abandons the burst. Trailing `bmem_rvalid` beats after reset release are ignored in IDLE.
- Hit latency: request accepted in cycle N -> `imem_resp` in N+1. Sustained hit throughput is one word per 2 cycles, because the initiator's address is still stale in the resp cycle.
- Miss latency: accept in N, `bmem_read` in N+1, last beat in M, `imem_resp` in M+1.
- `imem_resp` is never high for two consecutive cycles.
- `bmem_read` is deasserted the cycle after `bmem_ready`.
- `bmem_rvalid` outside MISS_FILL is ignored.
- Flush and request in the same cycle: flush wins; nothing is accepted.

## Structure
- Shared package `frontend_types`:
  - FSM enum `imem_resp_state_t`.
  - Constants `LINE_BYTES=32`, `LINE_OFFSET_W=5`, `WORD_SEL_W=3`.
- One sub-module, `imem_line_buffer`:
  - Holds tag, valid and data.
  - Handles beat write, invalidate, tag compare and word select.
- The top level holds the FSM, request latch, beat counter and squash flag.

## Test plan
- **Cold miss:** reset, then request 0x1eceb004 with bmem ready immediately; return beats D0..D3 over 4 cycles.
  - Required: `bmem_addr=0x1eceb000`.
  - Required: `imem_resp` one cycle after D3, with `imem_rdata=D0[63:32]`.
- **Hit after fill:** request 0x1eceb01c.
  - Required: `imem_resp` in the next cycle with `D3[63:32]`.
  - Required: `bmem_read` stays 0.
- **Flush during refill:** miss on 0x1eceb040, assert `flush` during the second beat, then re-request 0x1eceb048.
  - Required: no `imem_resp` for the squashed request.
  - Required: the 0x1eceb048 request hits, with resp 1 cycle after acceptance.
- **Back-pressure:** `bmem_ready` held low for 5 cycles.
  - Required: `bmem_read` and `bmem_addr` stable throughout.
  - Required: exactly one refill issued.
- **Reset mid-burst:** deassert `rst_n` after beat 1.
  - Required: all outputs 0 immediately; `line_valid=0`.
  - Required: the next request to the same line misses.
- **Same-cycle events:** raise `flush` and a request together in IDLE.
  - Required: the request is not accepted; `imem_resp=0` next cycle.
  - Required: the held request is accepted one cycle later.

Source files
------------

// File: rtl/frontend_types.sv
// rtl/frontend_types.sv - shared frontend types and instruction line geometry
//
// Purpose: FSM state enum for the imem responder plus the line geometry
//          constants shared by the responder and its line buffer.
// Ports:   none (package)
package frontend_types;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HIT_RESP  = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_FILL = 3'd3,
    ST_FILL_RESP = 3'd4
  } imem_resp_state_t;

  localparam int LINE_BYTES    = 32;
  localparam int LINE_OFFSET_W = 5;
  localparam int WORD_SEL_W    = 3;
  localparam int TAG_W         = 32 - LINE_OFFSET_W;

endpackage

// File: rtl/imem_line_buffer.sv
// rtl/imem_line_buffer.sv - single-line instruction buffer with tag compare
//
// Purpose: holds one line (valid, tag, data). Refill beats are written by
//          index; the line only becomes valid once the final beat lands.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset (clears valid/tag)
//   i_invalidate     drop the line (takes priority over i_fill_done)
//   i_beat_we        write i_beat_data into beat slot i_beat_idx
//   i_fill_done      mark the line valid with tag i_fill_tag
//   i_lookup_tag     tag to compare, o_hit = valid && match
//   i_word_sel       32-bit word index within the line, result on o_word
module imem_line_buffer
  import frontend_types::*;
#(
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_invalidate,
  input  logic                  i_beat_we,
  input  logic [CNT_W-1:0]      i_beat_idx,
  input  logic [DATA_W-1:0]     i_beat_data,
  input  logic                  i_fill_done,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [TAG_W-1:0]      i_lookup_tag,
  input  logic [WORD_SEL_W-1:0] i_word_sel,
  output logic                  o_hit,
  output logic [31:0]           o_word
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int NWORDS = LINE_BYTES / 4;

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [LINE_W-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else if (i_invalidate) begin
      r_valid <= 1'b0;
    end else if (i_fill_done) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
    end
  end

  // Data needs no reset: it is unreachable until r_valid is set by a full fill.
  always_ff @(posedge i_clk) begin
    if (i_beat_we) begin
      for (int b = 0; b < BURST_LEN; b++) begin
        if (i_beat_idx == CNT_W'(b)) begin
          r_data[b*DATA_W +: DATA_W] <= i_beat_data;
        end
      end
    end
  end

  assign o_hit = r_valid && (r_tag == i_lookup_tag);

  always_comb begin
    o_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (i_word_sel == WORD_SEL_W'(i)) begin
        o_word = r_data[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/imem_line_responder.sv
// rtl/imem_line_responder.sv - instruction-fetch responder backed by a one-line buffer
//
// Purpose: answers imem fetches from a single buffered line; hits respond the
//          cycle after acceptance, misses run a burst refill first. A flush
//          suppresses the response of the request in flight.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_imem_addr, i_imem_rmask      fetch request (rmask != 0 means request)
//   i_flush                        frontend redirect
//   o_imem_rdata, o_imem_resp      one-cycle response pulse and its word
//   o_bmem_addr, o_bmem_read       line-aligned refill request
//   i_bmem_ready                   refill request accepted
//   i_bmem_rvalid, i_bmem_rdata    refill beats, ascending from the line base
module imem_line_responder
  import frontend_types::*;
#(
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_imem_addr,
  input  logic [3:0]        i_imem_rmask,
  input  logic              i_flush,
  output logic [31:0]       o_imem_rdata,
  output logic              o_imem_resp,
  output logic [31:0]       o_bmem_addr,
  output logic              o_bmem_read,
  input  logic              i_bmem_ready,
  input  logic              i_bmem_rvalid,
  input  logic [DATA_W-1:0] i_bmem_rdata
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  imem_resp_state_t r_state;
  imem_resp_state_t w_state_next;
  logic [31:2]      r_req_addr;
  logic             r_squash;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_hit;
  logic        w_beat;
  logic        w_last_beat;
  logic [31:0] w_word;
  logic        w_unused_addr_lsbs;

  // Byte offset within the word is irrelevant to instruction fetch.
  assign w_unused_addr_lsbs = ^i_imem_addr[1:0];

  assign w_accept    = (r_state == ST_IDLE) && (i_imem_rmask != 4'b0) &&
                       !o_imem_resp && !i_flush;
  assign w_beat      = (r_state == ST_MISS_FILL) && i_bmem_rvalid;
  assign w_last_beat = w_beat && (r_cnt == LAST_BEAT);

  // Lookup uses the live address so the hit decision is made in the accept cycle;
  // the word select uses the latched address because the response comes a cycle later.
  imem_line_buffer #(
    .BURST_LEN (BURST_LEN),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W)
  ) u_line_buffer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_invalidate (w_accept && !w_hit),
    .i_beat_we    (w_beat),
    .i_beat_idx   (r_cnt),
    .i_beat_data  (i_bmem_rdata),
    .i_fill_done  (w_last_beat),
    .i_fill_tag   (r_req_addr[31:LINE_OFFSET_W]),
    .i_lookup_tag (i_imem_addr[31:LINE_OFFSET_W]),
    .i_word_sel   (r_req_addr[LINE_OFFSET_W-1:2]),
    .o_hit        (w_hit),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_addr <= '0;
      r_squash   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr <= i_imem_addr[31:2];
      end
      // The refill cannot be cancelled, so a flush only marks its response stale.
      if (r_state == ST_IDLE) begin
        r_squash <= 1'b0;
      end else if (i_flush && ((r_state == ST_MISS_REQ) || (r_state == ST_MISS_FILL))) begin
        r_squash <= 1'b1;
      end
      if ((r_state == ST_MISS_REQ) && i_bmem_ready) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = w_hit ? ST_HIT_RESP : ST_MISS_REQ;
        end
      end
      ST_HIT_RESP:  w_state_next = ST_IDLE;
      ST_MISS_REQ: begin
        if (i_bmem_ready) begin
          w_state_next = ST_MISS_FILL;
        end
      end
      ST_MISS_FILL: begin
        if (w_last_beat) begin
          w_state_next = ST_FILL_RESP;
        end
      end
      ST_FILL_RESP: w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_imem_resp = 1'b0;
    o_bmem_read = 1'b0;
    o_bmem_addr = '0;
    case (r_state)
      ST_HIT_RESP:  o_imem_resp = !i_flush;
      ST_FILL_RESP: o_imem_resp = !i_flush && !r_squash;
      ST_MISS_REQ: begin
        o_bmem_read = 1'b1;
        o_bmem_addr = {r_req_addr[31:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

  assign o_imem_rdata = o_imem_resp ? w_word : '0;

endmodule

// File: tb/tb_imem_line_responder.sv
// tb/tb_imem_line_responder.sv - self-checking bench for imem_line_responder
module tb_imem_line_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic        flush = 1'b0;
  logic        bmem_ready = 1'b0;
  logic        bmem_rvalid = 1'b0;
  logic [63:0] bmem_rdata = '0;
  logic [31:0] o_imem_rdata;
  logic        o_imem_resp;
  logic [31:0] o_bmem_addr;
  logic        o_bmem_read;

  int n_checks = 0;
  int n_errors = 0;
  int n_refill_exp = 0;
  int n_refill_dut = 0;
  logic prev_resp = 1'b0;
  logic prev_read = 1'b0;

  // Reference model: which line the buffer should hold.
  bit          m_valid = 1'b0;
  logic [26:0] m_tag = '0;

  imem_line_responder #(.BURST_LEN(4), .DATA_W(64)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_imem_addr  (imem_addr),
    .i_imem_rmask (imem_rmask),
    .i_flush      (flush),
    .o_imem_rdata (o_imem_rdata),
    .o_imem_resp  (o_imem_resp),
    .o_bmem_addr  (o_bmem_addr),
    .o_bmem_read  (o_bmem_read),
    .i_bmem_ready (bmem_ready),
    .i_bmem_rvalid(bmem_rvalid),
    .i_bmem_rdata (bmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Backing memory contents: an arbitrary function of the word address.
  function automatic logic [31:0] mem32(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9e3779b1) ^ 32'h3c6ef372;
  endfunction

  function automatic logic [63:0] beat64(input logic [31:0] line, input int b);
    logic [31:0] o;
    o = line + 32'(b * 8);
    return {mem32(o + 32'd4), mem32(o)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_imem_resp) chk("resp_single_cycle", {63'd0, prev_resp}, 64'd0);
      if (o_bmem_read && !prev_read) n_refill_dut++;
      prev_resp = o_imem_resp;
      prev_read = o_bmem_read;
    end else begin
      prev_resp = 1'b0;
      prev_read = 1'b0;
    end
  end

  // One request, playing the backing memory. flush_at: -1 none, 0..3 with that
  // beat, 4 during the refill request. Entered and left at posedge+1.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input bit exp_resp,
                       input int rdy_dly, input int gap, input int flush_at, input string nm);
    int beat;
    int stall;
    logic [31:0] line;
    line = {addr[31:5], 5'b0};
    imem_addr = addr;
    imem_rmask = 4'hf;
    #1;
    chk({nm, "/accept_cycle_resp"}, o_imem_resp, 0);
    tick();
    #1;
    chk({nm, "/miss_read"}, o_bmem_read, !exp_hit);
    if (exp_hit) begin
      chk({nm, "/hit_resp"}, o_imem_resp, 1);
      chk({nm, "/hit_rdata"}, o_imem_rdata, mem32(addr));
      imem_rmask = 4'h0;
      tick();
    end else begin
      n_refill_exp++;
      m_valid = 1'b0;
      for (int i = 0; i <= rdy_dly; i++) begin
        if (i > 0) #1;
        chk({nm, "/req_read"}, o_bmem_read, 1);
        chk({nm, "/req_addr"}, o_bmem_addr, line);
        chk({nm, "/req_resp"}, o_imem_resp, 0);
        bmem_ready = (i == rdy_dly);
        flush = (flush_at == 4) && (i == 0);
        tick();
        bmem_ready = 1'b0;
        flush = 1'b0;
      end
      beat = 0;
      stall = 0;
      while (beat < 4) begin
        #1;
        chk({nm, "/fill_read"}, o_bmem_read, 0);
        chk({nm, "/fill_resp_low"}, o_imem_resp, 0);
        bmem_rvalid = ($urandom_range(0, gap) == 0) || (stall >= 2);
        if (bmem_rvalid) begin
          bmem_rdata = beat64(line, beat);
          flush = (beat == flush_at);
          beat++;
          stall = 0;
        end else begin
          bmem_rdata = {$urandom, $urandom};
          stall++;
        end
        tick();
        bmem_rvalid = 1'b0;
        flush = 1'b0;
      end
      m_valid = 1'b1;
      m_tag = addr[31:5];
      #1;
      chk({nm, "/fill_resp"}, o_imem_resp, exp_resp);
      if (exp_resp) chk({nm, "/fill_rdata"}, o_imem_rdata, mem32(addr));
      imem_rmask = 4'h0;
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_rmask = 4'h0;
      imem_addr = $urandom;
      bmem_rvalid = 1'($urandom_range(0, 1));
      bmem_rdata = {$urandom, $urandom};
      #1;
      chk("idle_read", o_bmem_read, 0);
      chk("idle_resp", o_imem_resp, 0);
      tick();
      bmem_rvalid = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    bit          exp_resp;
    int          rdy_dly;
    int          flush_at;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] ra;
  bit rh;
  int rf;

  initial begin
    vecs[0] = '{32'h1eceb004, 1'b0, 1'b1, 0, -1};
    vecs[1] = '{32'h1eceb01c, 1'b1, 1'b1, 0, -1};
    vecs[2] = '{32'h1eceb040, 1'b0, 1'b0, 0,  1};
    vecs[3] = '{32'h1eceb048, 1'b1, 1'b1, 0, -1};
    vecs[4] = '{32'h00001234, 1'b0, 1'b1, 5, -1};
    vecs[5] = '{32'h00001220, 1'b1, 1'b1, 0, -1};
    vecs[6] = '{32'h00001200, 1'b0, 1'b0, 1,  4};
    vecs[7] = '{32'h00001204, 1'b1, 1'b1, 0, -1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_resp", o_imem_resp, 0);
    chk("reset_rdata", o_imem_rdata, 0);
    chk("reset_read", o_bmem_read, 0);
    chk("reset_bmem_addr", o_bmem_addr, 0);
    tick();
    rst_n = 1'b1;
    idle(1);

    foreach (vecs[i]) begin
      fetch(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_resp, vecs[i].rdy_dly, 0,
            vecs[i].flush_at, $sformatf("vec%0d", i));
      idle(1);
    end

    // Flush and request together: flush wins, the held request goes next cycle.
    imem_addr = 32'h00001208;
    imem_rmask = 4'hf;
    flush = 1'b1;
    #1;
    chk("same_cycle/resp0", o_imem_resp, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("same_cycle/not_accepted", o_imem_resp, 0);
    chk("same_cycle/no_read", o_bmem_read, 0);
    tick();
    #1;
    chk("same_cycle/resp", o_imem_resp, 1);
    chk("same_cycle/rdata", o_imem_rdata, mem32(32'h00001208));
    imem_rmask = 4'h0;
    tick();
    idle(1);

    // Flush during a hit response suppresses it.
    imem_addr = 32'h0000120c;
    imem_rmask = 4'hf;
    tick();
    flush = 1'b1;
    #1;
    chk("hit_flush/resp", o_imem_resp, 0);
    chk("hit_flush/rdata", o_imem_rdata, 0);
    imem_rmask = 4'h0;
    tick();
    flush = 1'b0;
    idle(1);

    // Reset after beat 1 of a refill.
    imem_addr = 32'h00400010;
    imem_rmask = 4'hf;
    tick();
    bmem_ready = 1'b1;
    #1;
    chk("rst_burst/read", o_bmem_read, 1);
    tick();
    bmem_ready = 1'b0;
    n_refill_exp++;
    bmem_rvalid = 1'b1;
    bmem_rdata = beat64(32'h00400000, 0);
    tick();
    bmem_rdata = beat64(32'h00400000, 1);
    tick();
    bmem_rdata = beat64(32'h00400000, 2);
    rst_n = 1'b0;
    imem_rmask = 4'h0;
    #1;
    chk("rst_burst/resp", o_imem_resp, 0);
    chk("rst_burst/rdata", o_imem_rdata, 0);
    chk("rst_burst/read0", o_bmem_read, 0);
    chk("rst_burst/bmem_addr", o_bmem_addr, 0);
    tick();
    rst_n = 1'b1;
    m_valid = 1'b0;
    bmem_rdata = beat64(32'h00400000, 3);
    #1;
    chk("rst_burst/trailing_read", o_bmem_read, 0);
    tick();
    bmem_rvalid = 1'b0;
    fetch(32'h00400010, 1'b0, 1'b1, 0, 0, -1, "rst_burst/refetch");
    idle(1);

    // Randomized traffic over a few lines against the line model.
    for (int t = 0; t < 40; t++) begin
      ra = 32'h8000_0000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2)
           + $urandom_range(0, 3);
      rh = m_valid && (ra[31:5] == m_tag);
      rf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      fetch(ra, rh, rh || (rf < 0), $urandom_range(0, 3), $urandom_range(0, 2), rf,
            $sformatf("rand%0d", t));
      idle($urandom_range(0, 2));
    end

    chk("refill_count", n_refill_dut, n_refill_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
